quad_encoder_counter: RTL and testbench

// - Parametrised quadrature decoder for motor encoders: synchronises and de-glitches A/B,

---
 rtl/quad_encoder_counter_if.sv | 42 ++++
 rtl/quad_encoder_counter.sv | 187 ++++++++++++++++++
 tb/tb_quad_encoder_counter.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/quad_encoder_counter_if.sv
// Encoder pins, control inputs and decoded outputs of quad_encoder_counter.
// Defining ENC_INDEX_EN adds the index channel (i_z in, o_index out).
interface quad_encoder_counter_if #(
   parameter int POS_W = 16,
   parameter int PER_W = 16
);
   logic             i_a;
   logic             i_b;
   logic             i_polarity;
   logic             i_clear;
   logic             i_load;
   logic [POS_W-1:0] i_load_val;
   logic             o_step;
   logic             o_dir;
   logic [POS_W-1:0] o_position;
   logic [PER_W-1:0] o_period;
   logic             o_period_valid;
   logic             o_error;
   logic             o_err_flag;
`ifdef ENC_INDEX_EN
   logic             i_z;
   logic             o_index;

   modport master (
      output i_a, i_b, i_z, i_polarity, i_clear, i_load, i_load_val,
      input  o_step, o_dir, o_position, o_period, o_period_valid, o_error, o_err_flag, o_index
   );
   modport slave (
      input  i_a, i_b, i_z, i_polarity, i_clear, i_load, i_load_val,
      output o_step, o_dir, o_position, o_period, o_period_valid, o_error, o_err_flag, o_index
   );
`else
   modport master (
      output i_a, i_b, i_polarity, i_clear, i_load, i_load_val,
      input  o_step, o_dir, o_position, o_period, o_period_valid, o_error, o_err_flag
   );
   modport slave (
      input  i_a, i_b, i_polarity, i_clear, i_load, i_load_val,
      output o_step, o_dir, o_position, o_period, o_period_valid, o_error, o_err_flag
   );
`endif
endinterface

// File: rtl/quad_encoder_counter.sv
// Quadrature decoder: sync + de-glitch A/B, decode steps, signed position, step period.
// Optional index channel (i_z / o_index, zeroes position) enabled by defining ENC_INDEX_EN.
module quad_encoder_counter #(
   parameter int POS_W      = 16,
   parameter int PER_W      = 16,
   parameter int FILT_DEPTH = 3
) (
   input logic                  i_clk,
   input logic                  i_rst,
   quad_encoder_counter_if.slave bus
);
   localparam int CNT_W = $clog2(FILT_DEPTH + 1);
   localparam logic [PER_W-1:0] PER_MAX = '1;

   logic [1:0]       r_ab_meta, r_ab_sync, r_ab_cand, r_ab_filt, r_ab_prev;
   logic [CNT_W-1:0] r_ab_cnt;
   logic             r_ab_upd;
   logic [CNT_W-1:0] w_ab_cnt_next;

   logic             r_step, r_dir, r_error, r_err_flag, r_period_valid, r_armed;
   logic [POS_W-1:0] r_position;
   logic [PER_W-1:0] r_period, r_per_cnt;

   logic [1:0]       w_idx_prev, w_idx_new, w_delta;
   logic             w_step, w_err, w_raw_dir, w_dir;

   // A candidate is counted only while it stays identical; any change restarts at 1
   always_comb begin
      w_ab_cnt_next = CNT_W'(1);
      if (r_ab_sync == r_ab_cand && r_ab_cnt != '0)
         w_ab_cnt_next = r_ab_cnt + 1'b1;
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_ab_meta <= 2'b00;
         r_ab_sync <= 2'b00;
         r_ab_cand <= 2'b00;
         r_ab_filt <= 2'b00;
         r_ab_prev <= 2'b00;
         r_ab_cnt  <= '0;
         r_ab_upd  <= 1'b0;
      end else begin
         r_ab_meta <= {bus.i_a, bus.i_b};
         r_ab_sync <= r_ab_meta;
         r_ab_upd  <= 1'b0;
         if (r_ab_sync == r_ab_filt) begin
            r_ab_cnt <= '0;
         end else if (w_ab_cnt_next == CNT_W'(FILT_DEPTH)) begin
            r_ab_prev <= r_ab_filt;
            r_ab_filt <= r_ab_sync;
            r_ab_upd  <= 1'b1;
            r_ab_cnt  <= '0;
         end else begin
            r_ab_cand <= r_ab_sync;
            r_ab_cnt  <= w_ab_cnt_next;
         end
      end
   end

   // Map {A,B} onto the cycle 00,10,11,01 as 0..3; the index delta gives direction
   assign w_idx_prev = {r_ab_prev[0], r_ab_prev[1] ^ r_ab_prev[0]};
   assign w_idx_new  = {r_ab_filt[0], r_ab_filt[1] ^ r_ab_filt[0]};

   always_comb begin
      w_step    = 1'b0;
      w_err     = 1'b0;
      w_raw_dir = 1'b0;
      w_delta   = w_idx_new - w_idx_prev;
      if (r_ab_upd) begin
         if (w_delta == 2'd2) begin
            w_err = 1'b1;
         end else begin
            w_step    = 1'b1;
            w_raw_dir = (w_delta == 2'd1);
         end
      end
      w_dir = w_raw_dir ^ bus.i_polarity;
   end

`ifdef ENC_INDEX_EN
   logic             r_z_meta, r_z_sync, r_z_cand, r_z_filt, r_z_rise, r_index;
   logic [CNT_W-1:0] r_z_cnt;
   logic [CNT_W-1:0] w_z_cnt_next;

   always_comb begin
      w_z_cnt_next = CNT_W'(1);
      if (r_z_sync == r_z_cand && r_z_cnt != '0)
         w_z_cnt_next = r_z_cnt + 1'b1;
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_z_meta <= 1'b0;
         r_z_sync <= 1'b0;
         r_z_cand <= 1'b0;
         r_z_filt <= 1'b0;
         r_z_rise <= 1'b0;
         r_z_cnt  <= '0;
         r_index  <= 1'b0;
      end else begin
         r_z_meta <= bus.i_z;
         r_z_sync <= r_z_meta;
         r_z_rise <= 1'b0;
         r_index  <= r_z_rise;
         if (r_z_sync == r_z_filt) begin
            r_z_cnt <= '0;
         end else if (w_z_cnt_next == CNT_W'(FILT_DEPTH)) begin
            r_z_filt <= r_z_sync;
            r_z_rise <= r_z_sync;
            r_z_cnt  <= '0;
         end else begin
            r_z_cand <= r_z_sync;
            r_z_cnt  <= w_z_cnt_next;
         end
      end
   end

   assign bus.o_index = r_index;
`endif

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_position <= '0;
      end else if (bus.i_clear) begin
         r_position <= '0;
      end else if (bus.i_load) begin
         r_position <= bus.i_load_val;
`ifdef ENC_INDEX_EN
      end else if (r_z_rise) begin
         r_position <= '0;
`endif
      end else if (w_step) begin
         r_position <= w_dir ? r_position + 1'b1 : r_position - 1'b1;
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_step         <= 1'b0;
         r_dir          <= 1'b0;
         r_error        <= 1'b0;
         r_err_flag     <= 1'b0;
         r_period       <= '0;
         r_period_valid <= 1'b0;
         r_per_cnt      <= '0;
         r_armed        <= 1'b0;
      end else begin
         r_step         <= w_step;
         r_error        <= w_err;
         r_period_valid <= 1'b0;
         if (w_step)
            r_dir <= w_dir;
         if (bus.i_clear)
            r_err_flag <= 1'b0;
         else if (w_err)
            r_err_flag <= 1'b1;
         // r_dir still holds the previous step's direction at this point
         if (bus.i_clear) begin
            r_per_cnt <= '0;
            r_armed   <= 1'b0;
         end else if (w_step) begin
            if (r_armed && w_dir == r_dir) begin
               r_period       <= r_per_cnt;
               r_period_valid <= 1'b1;
            end
            r_per_cnt <= PER_W'(1);
            r_armed   <= 1'b1;
         end else if (r_per_cnt != PER_MAX) begin
            r_per_cnt <= r_per_cnt + 1'b1;
            if (r_armed && r_per_cnt == PER_MAX - 1'b1) begin
               r_period       <= PER_MAX;
               r_period_valid <= 1'b1;
               r_armed        <= 1'b0;
            end
         end
      end
   end

   assign bus.o_step         = r_step;
   assign bus.o_dir          = r_dir;
   assign bus.o_position     = r_position;
   assign bus.o_period       = r_period;
   assign bus.o_period_valid = r_period_valid;
   assign bus.o_error        = r_error;
   assign bus.o_err_flag     = r_err_flag;
endmodule

// File: tb/tb_quad_encoder_counter.sv
// Randomised bench for quad_encoder_counter against a step-level behavioural model.
module tb_quad_encoder_counter;
   localparam int POS_W      = 16;
   localparam int PER_W      = 16;
   localparam int FILT_DEPTH = 3;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;
   int   n_tests = 0;
   int   n_fail = 0;
   int   n_valid = 0;

   // model state
   logic [POS_W-1:0] m_pos;
   logic [PER_W-1:0] m_period;
   bit               m_armed, m_last_dir, m_flag, pol;
   int               m_last_step, p_idx;
   logic [1:0]       seq [4];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   quad_encoder_counter_if #(.POS_W(POS_W), .PER_W(PER_W)) bus ();

   quad_encoder_counter #(.POS_W(POS_W), .PER_W(PER_W), .FILT_DEPTH(FILT_DEPTH)) dut (
      .i_clk (clk),
      .i_rst (rst),
      .bus   (bus)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      m_pos = '0; m_period = '0; m_armed = 0; m_last_dir = 0; m_flag = 0;
      m_last_step = cyc; p_idx = 0;
   endtask

   // kind: 0 forward, 1 reverse, 2 illegal (both pins change); gap = cycles to next edge
   task automatic do_move(input int kind, input int gap, input bit clr_hit);
      int steps, errs, stray, dcyc, since;
      logic sdir, sval;
      logic [POS_W-1:0] spos;
      logic [PER_W-1:0] sper;
      bit d, ev;
      steps = 0; errs = 0; stray = 0; sdir = 0; sval = 0; spos = '0; sper = '0;
      case (kind)
         0:       p_idx = (p_idx + 1) % 4;
         1:       p_idx = (p_idx + 3) % 4;
         default: p_idx = (p_idx + 2) % 4;
      endcase
      @(posedge clk); #1;
      bus.i_polarity = pol;
      {bus.i_a, bus.i_b} = seq[p_idx];
      dcyc = cyc;
      for (int i = 0; i < gap; i++) begin
         @(negedge clk);
         bus.i_clear = clr_hit && (i == FILT_DEPTH + 2);
         if (bus.o_step) begin
            steps++;
            sdir = bus.o_dir; spos = bus.o_position;
            sval = bus.o_period_valid; sper = bus.o_period;
         end else if (bus.o_period_valid) begin
            stray++;
         end
         if (bus.o_error) errs++;
      end
      bus.i_clear = 1'b0;
      since = dcyc - m_last_step;
      if (m_armed && since >= 65535) m_armed = 0;
      if (kind == 2) begin
         chk("illegal_err_pulse", errs, 1);
         chk("illegal_no_step", steps, 0);
         m_flag = 1;
      end else begin
         d = (kind == 0) ^ pol;
         chk("step_count", steps, 1);
         chk("step_no_err", errs, 0);
         ev = m_armed && (d == m_last_dir) && !clr_hit;
         if (clr_hit) begin
            m_pos = '0; m_armed = 0; m_flag = 0;
         end else begin
            m_pos = d ? m_pos + 1'b1 : m_pos - 1'b1;
         end
         chk("step_dir", sdir, d);
         chk("step_pos", spos, m_pos);
         chk("step_pvalid", sval, ev);
         if (ev) begin
            m_period = since[PER_W-1:0];
            n_valid++;
         end
         chk("step_period", sper, m_period);
         if (!clr_hit) begin
            m_armed = 1; m_last_dir = d; m_last_step = dcyc;
         end
      end
      chk("stray_pvalid", stray, 0);
      chk("err_flag", bus.o_err_flag, m_flag);
      chk("pos_after", bus.o_position, m_pos);
      $display("[TB] move kind=%0d gap=%0d pol=%0d clr=%0d pos=0x%0h model=0x%0h",
               kind, gap, pol, clr_hit, bus.o_position, m_pos);
   endtask

   task automatic load_op(input logic [POS_W-1:0] val);
      @(posedge clk); #1;
      bus.i_load = 1'b1; bus.i_load_val = val;
      @(posedge clk); #1;
      bus.i_load = 1'b0;
      m_pos = val;
      @(negedge clk);
      chk("load_pos", bus.o_position, m_pos);
      $display("[TB] load 0x%0h pos=0x%0h", val, bus.o_position);
   endtask

   task automatic clear_op();
      @(posedge clk); #1;
      bus.i_clear = 1'b1;
      @(posedge clk); #1;
      bus.i_clear = 1'b0;
      m_pos = '0; m_armed = 0; m_flag = 0;
      @(negedge clk);
      chk("clear_pos", bus.o_position, 0);
      chk("clear_flag", bus.o_err_flag, 0);
      $display("[TB] clear pos=0x%0h flag=%0d", bus.o_position, bus.o_err_flag);
   endtask

   task automatic glitch_op();
      logic [1:0] ab;
      int steps, errs;
      steps = 0; errs = 0;
      ab = seq[p_idx];
      @(posedge clk); #1;
      {bus.i_a, bus.i_b} = {~ab[1], ab[0]};
      repeat (FILT_DEPTH - 1) @(posedge clk);
      #1;
      {bus.i_a, bus.i_b} = ab;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (bus.o_step) steps++;
         if (bus.o_error) errs++;
      end
      chk("glitch_no_step", steps, 0);
      chk("glitch_no_err", errs, 0);
      chk("glitch_pos", bus.o_position, m_pos);
      $display("[TB] glitch steps=%0d errs=%0d", steps, errs);
   endtask

   initial begin
      int npv;
      logic [PER_W-1:0] sper;
      seq[0] = 2'b00; seq[1] = 2'b10; seq[2] = 2'b11; seq[3] = 2'b01;
      bus.i_a = 0; bus.i_b = 0; bus.i_polarity = 0; bus.i_clear = 0;
      bus.i_load = 0; bus.i_load_val = '0;
`ifdef ENC_INDEX_EN
      bus.i_z = 0;
`endif
      pol = 0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      model_reset();
      @(negedge clk);
      chk("rst_step", bus.o_step, 0);
      chk("rst_dir", bus.o_dir, 0);
      chk("rst_pos", bus.o_position, 0);
      chk("rst_period", bus.o_period, 0);
      chk("rst_pvalid", bus.o_period_valid, 0);
      chk("rst_error", bus.o_error, 0);
      chk("rst_flag", bus.o_err_flag, 0);

      n_valid = 0;
      for (int i = 0; i < 8; i++) do_move(0, 20, 0);
      chk("fwd8_pos", bus.o_position, 8);
      chk("fwd8_period", bus.o_period, 20);
      chk("fwd8_valid_count", n_valid, 7);

      pol = 1;
      for (int i = 0; i < 4; i++) do_move(1, 20, 0);
      chk("rev4_pos", bus.o_position, 12);
      do_move(0, 20, 0);
      chk("rev_fwd_pos", bus.o_position, 11);
      pol = 0;

      glitch_op();
      do_move(2, 20, 0);
      chk("illegal_flag", bus.o_err_flag, 1);
      clear_op();

      load_op(16'h7FFF);
      do_move(0, 20, 0);
      chk("wrap_pos", bus.o_position, 16'h8000);
      do_move(0, 20, 1);
      chk("clear_step_pos", bus.o_position, 0);

      for (int t = 0; t < 80; t++) begin
         int r;
         r = $urandom_range(0, 9);
         if ($urandom_range(0, 4) == 0) pol = ~pol;
         do_move((r < 5) ? 0 : (r < 9) ? 1 : 2, $urandom_range(8, 40),
                 (r < 9) && ($urandom_range(0, 19) == 0));
      end

      pol = 0;
      do_move(0, 20, 0);
      npv = 0; sper = '0;
      for (int i = 0; i < 65600; i++) begin
         @(negedge clk);
         if (bus.o_period_valid) begin
            npv++;
            sper = bus.o_period;
         end
      end
      chk("stall_valid_count", npv, 1);
      chk("stall_period", sper, 16'hFFFF);
      $display("[TB] stall pulses=%0d period=0x%0h", npv, sper);
      m_period = 16'hFFFF; m_armed = 0;
      do_move(0, 20, 0);

      load_op(16'd37);
      @(negedge clk); #1;
      rst = 1'b1;
      #1;
      chk("arst_pos", bus.o_position, 0);
      chk("arst_period", bus.o_period, 0);
      chk("arst_bits", {bus.o_step, bus.o_dir, bus.o_period_valid, bus.o_error, bus.o_err_flag}, 0);
      $display("[TB] async reset pos=0x%0h period=0x%0h", bus.o_position, bus.o_period);
      {bus.i_a, bus.i_b} = 2'b00;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      model_reset();
      do_move(0, 20, 0);
      chk("post_rst_pos", bus.o_position, 1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
